multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle successor to the single-cycle RV32I control unit. A Moore-style state machine sequences each instruction over 3–5 cycles with one shared ALU and one unified memory port. Memory accesses use a `mem_req`/`mem_ready` handshake, so variable-latency memory stalls the sequence. It sits between the instruction register/flags and the multi-cycle datapath's mux selects and write enables.

## Interface
- `OP_WIDTH`, 7, opcode width
- `FUNCT3_WIDTH`, 3, funct3 width
- `ALU_CTRL_WIDTH`, 4, ALUControl width
- `IMM_SRC_WIDTH`, 3, immediate-select width
- `ALU_OP_WIDTH`, 3, internal ALUOp width
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `op` / `funct3` / `funct7_5` in `OP_WIDTH` / `FUNCT3_WIDTH` / 1: fields from the instruction register.
- `Zero`, `N`, `C`, `V` in 1 each: ALU flags. `C` is the carry-out of A + ~B + 1.
- `mem_ready` in 1: memory has completed the current request.
- `mem_req` out 1: memory request.
- `MemWrite` out 1: store enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction-register write enable.
- `PCWrite` out 1: PC write enable.
- `RegWrite` out 1: register-file write enable.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `ALUSrcB` out 2: ALU B select. 00 = rs2, 01 = imm, 10 = const 4.
- `ALUControl` out `ALU_CTRL_WIDTH`: ALU operation.
- `ImmSrc` out `IMM_SRC_WIDTH`: immediate format.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `Trap` out 1: sticky illegal-instruction flag.

## Operation
- **ImmSrc** is decoded from `op` in every state: I = 000, S = 001, B = 010, J = 011, U = 100.
- **ALUOp** values: ADD = 000, SUB = 001, R-decode = 010, I-decode = 011. ALUOp is mapped to `ALUControl` via the existing `alu_decoder`.
- **Default outputs in every state:** all enables 0; `mem_req`=0, `AdrSrc`=0, `ResultSrc`=00, `ALUSrcA`=00, `ALUSrcB`=00, ALUOp=ADD.
- **States.** Each entry gives the non-default outputs, then the next state.
  - FETCH: `mem_req`, A=00, B=10, `ResultSrc`=10, `IRWrite`=`PCWrite`=`mem_ready`. Go to DECODE on `mem_ready`, else stay.
  - DECODE: A=01, B=01 (branch/jal target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - anything else → ILLEGAL handling
  - MEMADR: A=10, B=01. Go to MEMWRITE if `op[5]`, else MEMREAD.
  - MEMREAD: `mem_req`, `AdrSrc`=1. Go to MEMWB on `mem_ready`.
  - MEMWB: `ResultSrc`=01, `RegWrite`. Go to FETCH.
  - MEMWRITE: `mem_req`, `MemWrite`, `AdrSrc`=1, all held until `mem_ready`. Go to FETCH.
  - EXECR: A=10, B=00, ALUOp=R-decode. Go to ALUWB.
  - EXECI: A=10, B=01, ALUOp=I-decode. Go to ALUWB.
  - LUI: A=11, B=01. Go to ALUWB.
  - AUIPC: A=01, B=01. Go to ALUWB.
  - ALUWB: `RegWrite`, `ResultSrc`=00. Go to FETCH.
  - BRANCH: A=10, B=00, SUB, `ResultSrc`=00, `PCWrite`=taken. Go to FETCH.
  - JAL: `ResultSrc`=00, `PCWrite`. Go to LINK.
  - JALR: A=10, B=01, `ResultSrc`=10, `PCWrite`. Go to LINK.
  - LINK: A=01, B=10, `ResultSrc`=10, `RegWrite`. Go to FETCH.
- **Branch taken** is decided by funct3:
  - 000 beq: `Zero`
  - 001 bne: `~Zero`
  - 100 blt: `N^V`
  - 101 bge: `~(N^V)`
  - 110 bltu: `~C`
  - 111 bgeu: `C`
  - 010 and 011: not taken, treated as illegal.
- **`instr_done`** is high in MEMWB, ALUWB, LINK and BRANCH, and in MEMWRITE when `mem_ready` is high.

## Timing
- `PCWrite` in BRANCH is Mealy, depending on the flags. All other outputs are Moore from the state register, plus the `mem_ready` gating in FETCH and MEMWRITE.
- Latency with `mem_ready` tied high:
  - branch: 3 cycles
  - store, R-type, I-type, LUI, AUIPC, JAL, JALR: 4 cycles
  - load: 5 cycles
- Each cycle of `mem_ready`=0 adds one cycle in FETCH, MEMREAD or MEMWRITE. The outputs in those states stay constant while stalled.
- `rst` asserted asynchronously: state goes to FETCH immediately. While `rst` is high, all enables and `mem_req` are forced to 0, `Trap`=0, and the muxes take FETCH values.
- The first fetch request occurs in the first cycle after `rst` deasserts.
- Reset mid-store drops `MemWrite` combinationally. No partial-state recovery is provided.

## Configuration
- Macro: `MCU_TRAP_EN`.
- With the macro defined:
  - An illegal opcode or branch funct3 moves to TRAP.
  - TRAP sets `Trap`=1 with all enables 0, and stays there until `rst`.
- Without the macro:
  - An illegal instruction returns to FETCH as a no-op, with `instr_done` pulsed in DECODE.
  - The TRAP state is absent and `Trap` is tied to 0.

## Structure
- Package `control_pkg`: the state enum, opcode localparams, ALUOp codes, ImmSrc codes, and the ALUSrcA/ALUSrcB/ResultSrc encodings.
- Sub-module `branch_cond` (combinational): maps funct3 and the flags to `taken` and `illegal`.
- `alu_decoder` is reused unmodified.

## Test plan
- **Reset:** assert `rst` mid-MEMWRITE.
  - `MemWrite` and `mem_req` drop to 0 in the same cycle.
  - After release, FETCH with `mem_req`=1 follows.
- **add (0110011, funct3 000, funct7_5 0), `mem_ready`=1:** sequence is FETCH, DECODE, EXECR, ALUWB; `RegWrite` and `instr_done` in cycle 4.
- **lw with `mem_ready` low for 3 cycles in MEMREAD:**
  - `AdrSrc`=1 and `mem_req`=1 held for 4 cycles.
  - MEMWB `RegWrite` follows, `ResultSrc`=01.
- **blt (funct3 100):**
  - N=1, V=0 → `PCWrite`=1 in BRANCH.
  - N=1, V=1 → `PCWrite`=0.
  - bltu with C=0 → taken.
- **jalr:** `PCWrite` with `ResultSrc`=10 in JALR, then LINK `RegWrite` with A=01, B=10.
- **Opcode 0000000:**
  - With `MCU_TRAP_EN`: `Trap`=1 and sticky, no enables.
  - Without it: back to FETCH after DECODE.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes, ALUOp, ImmSrc and mux selects.
// Also holds the per-state Moore control word table, registered by the top one cycle ahead.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_LUI,
    S_AUIPC,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK
`ifdef MCU_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_RDEC = 3'b010;
  localparam logic [2:0] ALUOP_IDEC = 3'b011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       done;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;

  // FETCH ir/pc_write and MEMWRITE done are further gated by mem_ready in the top.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
        c.done      = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_RDEC;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_IDEC;
      end
      S_LUI: begin
        c.alu_src_a = SRCA_ZERO;
        c.alu_src_b = SRCB_IMM;
      end
      S_AUIPC: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_ALUOUT;
        c.done       = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.done       = 1'b1;
      end
      S_JAL: begin
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
      end
      S_JALR: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALURESULT;
        c.pc_write   = 1'b1;
      end
      S_LINK: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus funct3/funct7_5 to the ALU operation code.
// Purely combinational, no handshake.
module alu_decoder #(
  parameter int ALU_OP_WIDTH   = 3,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic [ALU_OP_WIDTH-1:0]   alu_op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      funct7_5,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control
);

  localparam logic [ALU_CTRL_WIDTH-1:0] AC_ADD  = ALU_CTRL_WIDTH'(0);
  localparam logic [ALU_CTRL_WIDTH-1:0] AC_SUB  = ALU_CTRL_WIDTH'(1);
  localparam logic [ALU_CTRL_WIDTH-1:0] AC_AND  = ALU_CTRL_WIDTH'(2);
  localparam logic [ALU_CTRL_WIDTH-1:0] AC_OR   = ALU_CTRL_WIDTH'(3);
  localparam logic [ALU_CTRL_WIDTH-1:0] AC_XOR  = ALU_CTRL_WIDTH'(4);
  localparam logic [ALU_CTRL_WIDTH-1:0] AC_SLT  = ALU_CTRL_WIDTH'(5);
  localparam logic [ALU_CTRL_WIDTH-1:0] AC_SLTU = ALU_CTRL_WIDTH'(6);
  localparam logic [ALU_CTRL_WIDTH-1:0] AC_SLL  = ALU_CTRL_WIDTH'(7);
  localparam logic [ALU_CTRL_WIDTH-1:0] AC_SRL  = ALU_CTRL_WIDTH'(8);
  localparam logic [ALU_CTRL_WIDTH-1:0] AC_SRA  = ALU_CTRL_WIDTH'(9);

  logic is_r;

  assign is_r = (alu_op == ALU_OP_WIDTH'(2));

  always_comb begin
    alu_control = AC_ADD;
    case (alu_op)
      ALU_OP_WIDTH'(0): alu_control = AC_ADD;
      ALU_OP_WIDTH'(1): alu_control = AC_SUB;
      ALU_OP_WIDTH'(2), ALU_OP_WIDTH'(3): begin
        case (funct3)
          // funct7_5 selects SUB only for register-register ops; addi ignores it
          FUNCT3_WIDTH'(0): alu_control = (is_r && funct7_5) ? AC_SUB : AC_ADD;
          FUNCT3_WIDTH'(1): alu_control = AC_SLL;
          FUNCT3_WIDTH'(2): alu_control = AC_SLT;
          FUNCT3_WIDTH'(3): alu_control = AC_SLTU;
          FUNCT3_WIDTH'(4): alu_control = AC_XOR;
          FUNCT3_WIDTH'(5): alu_control = funct7_5 ? AC_SRA : AC_SRL;
          FUNCT3_WIDTH'(6): alu_control = AC_OR;
          default:          alu_control = AC_AND;
        endcase
      end
      default: alu_control = AC_ADD;
    endcase
  end

endmodule

// File: rtl/branch_cond.sv
// Branch resolution from funct3 and the ALU flags of rs1 - rs2.
// Purely combinational; flags illegal funct3 encodings (010/011) as never taken.
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       n,
  input  logic       c,
  input  logic       v,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = n ^ v;
      3'b101:  taken = ~(n ^ v);
      // c is carry-out of a + ~b + 1, so c=1 means no borrow (a >= b unsigned)
      3'b110:  taken = ~c;
      3'b111:  taken = c;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: 3-5 cycles per instruction, stalls in FETCH/MEMREAD/MEMWRITE until mem_ready.
// Illegal instructions become a no-op, or a sticky TRAP state when MCU_TRAP_EN is defined.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int OP_WIDTH       = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int IMM_SRC_WIDTH  = 3,
  parameter int ALU_OP_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OP_WIDTH-1:0]       op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      funct7_5,
  input  logic                      Zero,
  input  logic                      N,
  input  logic                      C,
  input  logic                      V,
  input  logic                      mem_ready,
  output logic                      mem_req,
  output logic                      MemWrite,
  output logic                      AdrSrc,
  output logic                      IRWrite,
  output logic                      PCWrite,
  output logic                      RegWrite,
  output logic [1:0]                ResultSrc,
  output logic [1:0]                ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
  output logic                      instr_done,
  output logic                      Trap
);

  state_t state, state_n;
  ctrl_t  ctrl_q;
  logic   br_taken, br_illegal, op_illegal;
  logic   run, rdy_gate, decode_illegal;
  state_t illegal_target;

  branch_cond u_branch_cond (
    .funct3  (funct3),
    .zero    (Zero),
    .n       (N),
    .c       (C),
    .v       (V),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  alu_decoder #(
    .ALU_OP_WIDTH   (ALU_OP_WIDTH),
    .FUNCT3_WIDTH   (FUNCT3_WIDTH),
    .ALU_CTRL_WIDTH (ALU_CTRL_WIDTH)
  ) u_alu_decoder (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (ALUControl)
  );

`ifdef MCU_TRAP_EN
  assign illegal_target = S_TRAP;
`else
  assign illegal_target = S_FETCH;
`endif

  always_comb begin
    op_illegal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_illegal = 1'b0;
      OP_BRANCH: op_illegal = br_illegal;
      default:   op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:         ImmSrc = IMM_S;
      OP_BRANCH:        ImmSrc = IMM_B;
      OP_JAL:           ImmSrc = IMM_J;
      OP_LUI, OP_AUIPC: ImmSrc = IMM_U;
      default:          ImmSrc = IMM_I;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:    state_n = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_illegal) begin
          state_n = illegal_target;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_n = S_MEMADR;
            OP_R:              state_n = S_EXECR;
            OP_I:              state_n = S_EXECI;
            OP_BRANCH:         state_n = S_BRANCH;
            OP_JAL:            state_n = S_JAL;
            OP_JALR:           state_n = S_JALR;
            OP_LUI:            state_n = S_LUI;
            OP_AUIPC:          state_n = S_AUIPC;
            default:           state_n = illegal_target;
          endcase
        end
      end
      S_MEMADR:   state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_n = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_n = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_n = S_ALUWB;
      S_JAL, S_JALR: state_n = S_LINK;
`ifdef MCU_TRAP_EN
      S_TRAP:     state_n = S_TRAP;
`endif
      default:    state_n = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so Moore outputs come straight off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH);
    end else begin
      state  <= state_n;
      ctrl_q <= state_ctrl(state_n);
    end
  end

  assign run      = ~rst;
  assign rdy_gate = (state == S_FETCH || state == S_MEMWRITE) ? mem_ready : 1'b1;

`ifdef MCU_TRAP_EN
  assign decode_illegal = 1'b0;
  assign Trap           = run & (state == S_TRAP);
`else
  assign decode_illegal = (state == S_DECODE) & op_illegal;
  assign Trap           = 1'b0;
`endif

  assign mem_req    = run & ctrl_q.mem_req;
  assign MemWrite   = run & ctrl_q.mem_write;
  assign AdrSrc     = ctrl_q.adr_src;
  assign IRWrite    = run & ctrl_q.ir_write & rdy_gate;
  assign PCWrite    = run & ((ctrl_q.pc_write & rdy_gate) | ((state == S_BRANCH) & br_taken));
  assign RegWrite   = run & ctrl_q.reg_write;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign instr_done = run & ((ctrl_q.done & rdy_gate) | decode_illegal);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed per-cycle vector bench for multicycle_control_unit plus a reset-mid-store sequence.
module tb_multicycle_control_unit;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011,
                         T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                         T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111,
                         T_ZERO = 7'b0000000;
  localparam logic [3:0] AC_ADD = 4'd0, AC_SUB = 4'd1, AC_SRA = 4'd9;

  typedef struct packed {
    logic req, mw, adr, irw, pcw, rw;
    logic [1:0] rs, a, b;
    logic done, trap;
    logic [3:0] alu;
  } exp_t;

  typedef struct {
    string      nm;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] fl;   // {Zero, N, C, V}
    logic       mr;
    exp_t       x;
    logic       ci;
    logic [2:0] imm;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       Zero = 1'b0, N = 1'b0, C = 1'b0, V = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, instr_done, Trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t       tbl[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic [3:0] cur_fl;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .N(N), .C(C), .V(V), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .instr_done(instr_done), .Trap(Trap)
  );

  always #5 clk = ~clk;

  function automatic exp_t e(logic req, logic mw, logic adr, logic irw, logic pcw, logic rw,
                             logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                             logic done, logic trap, logic [3:0] alu);
    return {req, mw, adr, irw, pcw, rw, rs, a, b, done, trap, alu};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic instr(logic [6:0] o, logic [2:0] f3, logic f7, logic [3:0] fl);
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_fl = fl;
  endtask

  task automatic step(string nm, logic mr, exp_t x, logic ci = 1'b0, logic [2:0] imm = 3'b000);
    vec_t t;
    t.nm = nm; t.rst = 1'b0; t.op = cur_op; t.f3 = cur_f3; t.f7 = cur_f7; t.fl = cur_fl;
    t.mr = mr; t.x = x; t.ci = ci; t.imm = imm;
    tbl.push_back(t);
  endtask

  task automatic rst_step(string nm);
    vec_t t;
    t.nm = nm; t.rst = 1'b1; t.op = T_ZERO; t.f3 = '0; t.f7 = 1'b0; t.fl = '0; t.mr = 1'b1;
    t.x = e(0,0,0,0,0,0,2'b10,2'b00,2'b10,0,0,AC_ADD); t.ci = 1'b0; t.imm = '0;
    tbl.push_back(t);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    exp_t f1, f0, dec, alu_wb, link, br_t, br_n, trap_x, ill_dec, obs;

    f1      = e(1,0,0,1,1,0,2'b10,2'b00,2'b10,0,0,AC_ADD);
    f0      = e(1,0,0,0,0,0,2'b10,2'b00,2'b10,0,0,AC_ADD);
    dec     = e(0,0,0,0,0,0,2'b00,2'b01,2'b01,0,0,AC_ADD);
    alu_wb  = e(0,0,0,0,0,1,2'b00,2'b00,2'b00,1,0,AC_ADD);
    link    = e(0,0,0,0,0,1,2'b10,2'b01,2'b10,1,0,AC_ADD);
    br_t    = e(0,0,0,0,1,0,2'b00,2'b10,2'b00,1,0,AC_SUB);
    br_n    = e(0,0,0,0,0,0,2'b00,2'b10,2'b00,1,0,AC_SUB);
    trap_x  = e(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,AC_ADD);
`ifdef MCU_TRAP_EN
    ill_dec = dec;
`else
    ill_dec = e(0,0,0,0,0,0,2'b00,2'b01,2'b01,1,0,AC_ADD);
`endif

    rst_step("reset");
    instr(T_R, 3'b000, 1'b0, 4'b0000);
    step("add fetch", 1, f1); step("add decode", 1, dec);
    step("add execr", 1, e(0,0,0,0,0,0,2'b00,2'b10,2'b00,0,0,AC_ADD));
    step("add aluwb", 1, alu_wb);
    instr(T_R, 3'b000, 1'b1, 4'b0000);
    step("sub fetch", 1, f1); step("sub decode", 1, dec);
    step("sub execr", 1, e(0,0,0,0,0,0,2'b00,2'b10,2'b00,0,0,AC_SUB));
    step("sub aluwb", 1, alu_wb);
    instr(T_LOAD, 3'b010, 1'b0, 4'b0000);
    step("lw fetch stall", 0, f0); step("lw fetch", 1, f1); step("lw decode", 1, dec, 1, 3'b000);
    step("lw memadr", 1, e(0,0,0,0,0,0,2'b00,2'b10,2'b01,0,0,AC_ADD));
    for (int k = 0; k < 3; k++) step("lw memread stall", 0, e(1,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,AC_ADD));
    step("lw memread", 1, e(1,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,AC_ADD));
    step("lw memwb", 1, e(0,0,0,0,0,1,2'b01,2'b00,2'b00,1,0,AC_ADD));
    instr(T_STORE, 3'b010, 1'b0, 4'b0000);
    step("sw fetch", 1, f1); step("sw decode", 1, dec, 1, 3'b001);
    step("sw memadr", 1, e(0,0,0,0,0,0,2'b00,2'b10,2'b01,0,0,AC_ADD));
    step("sw memwrite stall", 0, e(1,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,AC_ADD));
    step("sw memwrite", 1, e(1,1,1,0,0,0,2'b00,2'b00,2'b00,1,0,AC_ADD));
    instr(T_I, 3'b101, 1'b1, 4'b0000);
    step("srai fetch", 1, f1); step("srai decode", 1, dec);
    step("srai execi", 1, e(0,0,0,0,0,0,2'b00,2'b10,2'b01,0,0,AC_SRA));
    step("srai aluwb", 1, alu_wb);
    instr(T_I, 3'b000, 1'b1, 4'b0000);
    step("addi fetch", 1, f1); step("addi decode", 1, dec);
    step("addi execi", 1, e(0,0,0,0,0,0,2'b00,2'b10,2'b01,0,0,AC_ADD));
    step("addi aluwb", 1, alu_wb);
    instr(T_BR, 3'b100, 1'b0, 4'b0100);
    step("blt taken fetch", 1, f1); step("blt decode", 1, dec, 1, 3'b010); step("blt N1V0 branch", 1, br_t);
    instr(T_BR, 3'b100, 1'b0, 4'b0101);
    step("blt nt fetch", 1, f1); step("blt nt decode", 1, dec); step("blt N1V1 branch", 1, br_n);
    instr(T_BR, 3'b110, 1'b0, 4'b0000);
    step("bltu fetch", 1, f1); step("bltu decode", 1, dec); step("bltu C0 branch", 1, br_t);
    instr(T_BR, 3'b111, 1'b0, 4'b0000);
    step("bgeu fetch", 1, f1); step("bgeu decode", 1, dec); step("bgeu C0 branch", 1, br_n);
    instr(T_BR, 3'b000, 1'b0, 4'b1000);
    step("beq fetch", 1, f1); step("beq decode", 1, dec); step("beq Z1 branch", 1, br_t);
    instr(T_BR, 3'b001, 1'b0, 4'b1000);
    step("bne fetch", 1, f1); step("bne decode", 1, dec); step("bne Z1 branch", 1, br_n);
    instr(T_BR, 3'b101, 1'b0, 4'b0001);
    step("bge fetch", 1, f1); step("bge decode", 1, dec); step("bge N0V1 branch", 1, br_n);
    instr(T_JAL, 3'b000, 1'b0, 4'b0000);
    step("jal fetch", 1, f1); step("jal decode", 1, dec, 1, 3'b011);
    step("jal jal", 1, e(0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,AC_ADD));
    step("jal link", 1, link);
    instr(T_JALR, 3'b000, 1'b0, 4'b0000);
    step("jalr fetch", 1, f1); step("jalr decode", 1, dec);
    step("jalr jalr", 1, e(0,0,0,0,1,0,2'b10,2'b10,2'b01,0,0,AC_ADD));
    step("jalr link", 1, link);
    instr(T_LUI, 3'b000, 1'b0, 4'b0000);
    step("lui fetch", 1, f1); step("lui decode", 1, dec, 1, 3'b100);
    step("lui lui", 1, e(0,0,0,0,0,0,2'b00,2'b11,2'b01,0,0,AC_ADD));
    step("lui aluwb", 1, alu_wb);
    instr(T_AUIPC, 3'b000, 1'b0, 4'b0000);
    step("auipc fetch", 1, f1); step("auipc decode", 1, dec, 1, 3'b100);
    step("auipc auipc", 1, e(0,0,0,0,0,0,2'b00,2'b01,2'b01,0,0,AC_ADD));
    step("auipc aluwb", 1, alu_wb);
    instr(T_BR, 3'b010, 1'b0, 4'b1111);
    step("bad br fetch", 1, f1); step("bad br decode", 1, ill_dec);
`ifdef MCU_TRAP_EN
    step("bad br trap", 1, trap_x);
    rst_step("reset after trap");
`endif
    instr(T_ZERO, 3'b000, 1'b0, 4'b0000);
    step("op0 fetch", 1, f1); step("op0 decode", 1, ill_dec);
`ifdef MCU_TRAP_EN
    step("op0 trap", 1, trap_x); step("op0 trap sticky", 0, trap_x); step("op0 trap held", 1, trap_x);
    rst_step("reset clears trap");
    step("fetch after trap", 1, f1);
`else
    step("op0 back to fetch", 0, f0);
`endif

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst; op = tbl[i].op; funct3 = tbl[i].f3; funct7_5 = tbl[i].f7;
      {Zero, N, C, V} = tbl[i].fl; mem_ready = tbl[i].mr;
      @(negedge clk);
      obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
             instr_done, Trap, ALUControl};
      check($sformatf("vec%0d %s", i, tbl[i].nm), 32'(obs), 32'(tbl[i].x));
      if (tbl[i].ci) check($sformatf("vec%0d %s ImmSrc", i, tbl[i].nm), 32'(ImmSrc), 32'(tbl[i].imm));
    end

    // Reset asserted in the middle of a stalled store
    @(posedge clk); #1 rst = 1'b1; mem_ready = 1'b1; op = T_STORE; funct3 = 3'b010;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    check("midstore MemWrite before rst", 32'(MemWrite), 32'd1);
    check("midstore mem_req before rst", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midstore MemWrite in rst", 32'(MemWrite), 32'd0);
    check("midstore mem_req in rst", 32'(mem_req), 32'd0);
    check("midstore ALUSrcB in rst", 32'(ALUSrcB), 32'd2);
    @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("post-rst fetch mem_req", 32'(mem_req), 32'd1);
    check("post-rst fetch IRWrite", 32'(IRWrite), 32'd1);
    check("post-rst fetch MemWrite", 32'(MemWrite), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
